core_writeback: RTL and testbench

// - Writeback stage directly upstream of the core register file.
// - Merges two result streams into the single regfile write port (a2/wd2/we2):
//   ALU/EX results and load-unit results.
// - Buffers loads in a small FIFO, arbitrates with starvation protection, and

---
 rtl/core_writeback_if.sv | 41 ++++
 rtl/core_writeback.sv | 153 +++++++++++++++
 tb/tb_core_writeback.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/core_writeback_if.sv
// Writeback-stage bundle: EX and load result streams, load-issue notification,
// and the regfile write port with its scoreboard and illegal-rd flag.
interface core_writeback_if #(
    parameter int XLEN    = 32,
    parameter int NUMREGS = 32
);
    logic               ex_valid;
    logic               ex_ready;
    logic [4:0]         ex_rd;
    logic [XLEN-1:0]    ex_data;

    logic               ld_valid;
    logic               ld_ready;
    logic [4:0]         ld_rd;
    logic [XLEN-1:0]    ld_data;

    logic               iss_valid;
    logic [4:0]         iss_rd;

    logic [4:0]         rf_a2;
    logic [XLEN-1:0]    rf_wd2;
    logic               rf_we2;
    logic [NUMREGS-1:0] sb_busy;
    logic               illegal_rd;

    modport slave (
        input  ex_valid, ex_rd, ex_data,
        input  ld_valid, ld_rd, ld_data,
        input  iss_valid, iss_rd,
        output ex_ready, ld_ready,
        output rf_a2, rf_wd2, rf_we2, sb_busy, illegal_rd
    );

    modport master (
        output ex_valid, ex_rd, ex_data,
        output ld_valid, ld_rd, ld_data,
        output iss_valid, iss_rd,
        input  ex_ready, ld_ready,
        input  rf_a2, rf_wd2, rf_we2, sb_busy, illegal_rd
    );
endinterface

// File: rtl/core_writeback.sv
// Writeback stage: merges EX results and FIFO-buffered load results onto the
// single regfile write port, with starvation-bounded arbitration and a load scoreboard.
package config_pkg;
    typedef struct packed {
        int unsigned XLEN;
        logic        E_SUPPORTED;
    } cfg_t;

    localparam cfg_t DEFAULT_CONF = '{XLEN: 32, E_SUPPORTED: 1'b0};
endpackage

module core_writeback #(
    parameter config_pkg::cfg_t CONF       = config_pkg::DEFAULT_CONF,
    parameter int               LQ_DEPTH   = 2,
    parameter int               STARVE_MAX = 4
) (
    input logic               clk,
    input logic               rst,
    core_writeback_if.slave   wb
);
    localparam int XLEN    = int'(CONF.XLEN);
    localparam int NUMREGS = CONF.E_SUPPORTED ? 16 : 32;
    localparam int PTR_W   = $clog2(LQ_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ST_W    = $clog2(STARVE_MAX + 1);

    logic [4:0]         fifo_rd_q   [LQ_DEPTH];
    logic [4:0]         fifo_rd_d   [LQ_DEPTH];
    logic [XLEN-1:0]    fifo_data_q [LQ_DEPTH];
    logic [XLEN-1:0]    fifo_data_d [LQ_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ST_W-1:0]    starve_q, starve_d;

    logic               rf_we2_q, rf_we2_d;
    logic [4:0]         rf_a2_q, rf_a2_d;
    logic [XLEN-1:0]    rf_wd2_q, rf_wd2_d;
    logic               illegal_q, illegal_d;
    logic [NUMREGS-1:0] sb_q, sb_d;

    logic               fifo_empty;
    logic               fifo_full;
    logic               force_ld;
    logic               push;
    logic               commit_ex;
    logic               commit_ld;
    logic               commit;
    logic [4:0]         commit_rd;
    logic [XLEN-1:0]    commit_data;
    logic               rd_illegal;

    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == CNT_W'(LQ_DEPTH));
    assign force_ld    = (starve_q == ST_W'(STARVE_MAX)) && !fifo_empty;
    // ld_ready comes from the registered count, so a pop never frees a slot in the same cycle
    assign push        = wb.ld_valid && !fifo_full;
    assign commit_ex   = wb.ex_valid && !force_ld;
    assign commit_ld   = !commit_ex && !fifo_empty;
    assign commit      = commit_ex || commit_ld;
    assign commit_rd   = commit_ex ? wb.ex_rd   : fifo_rd_q[rd_ptr_q];
    assign commit_data = commit_ex ? wb.ex_data : fifo_data_q[rd_ptr_q];
    assign rd_illegal  = CONF.E_SUPPORTED && commit_rd[4];

    assign wb.ex_ready   = !force_ld;
    assign wb.ld_ready   = !fifo_full;
    assign wb.rf_we2     = rf_we2_q;
    assign wb.rf_a2      = rf_a2_q;
    assign wb.rf_wd2     = rf_wd2_q;
    assign wb.illegal_rd = illegal_q;
    assign wb.sb_busy    = sb_q;

    always_comb begin
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (push) begin
            fifo_rd_d[wr_ptr_q]   = wb.ld_rd;
            fifo_data_d[wr_ptr_q] = wb.ld_data;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end
        if (commit_ld) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(commit_ld);
    end

    // Counts EX wins only while loads wait; any load commit or an empty FIFO resets it.
    always_comb begin
        starve_d = starve_q;
        if (commit_ld || fifo_empty) begin
            starve_d = '0;
        end else if (commit_ex && (starve_q != ST_W'(STARVE_MAX))) begin
            starve_d = starve_q + ST_W'(1);
        end
    end

    always_comb begin
        rf_we2_d  = commit && (commit_rd != 5'd0) && !rd_illegal;
        illegal_d = commit && rd_illegal;
        rf_a2_d   = rf_a2_q;
        rf_wd2_d  = rf_wd2_q;
        if (commit) begin
            rf_a2_d  = commit_rd;
            rf_wd2_d = commit_data;
        end
    end

    // Set after clear so a same-cycle reissue of the register keeps it busy.
    always_comb begin
        sb_d = sb_q;
        for (int i = 0; i < NUMREGS; i++) begin
            if (commit_ld && (commit_rd == 5'(i))) begin
                sb_d[i] = 1'b0;
            end
        end
        for (int i = 0; i < NUMREGS; i++) begin
            if (wb.iss_valid && (wb.iss_rd == 5'(i))) begin
                sb_d[i] = 1'b1;
            end
        end
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_rd_q   <= '{default: '0};
            fifo_data_q <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            rf_we2_q    <= 1'b0;
            rf_a2_q     <= '0;
            rf_wd2_q    <= '0;
            illegal_q   <= 1'b0;
            sb_q        <= '0;
        end else begin
            fifo_rd_q   <= fifo_rd_d;
            fifo_data_q <= fifo_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            rf_we2_q    <= rf_we2_d;
            rf_a2_q     <= rf_a2_d;
            rf_wd2_q    <= rf_wd2_d;
            illegal_q   <= illegal_d;
            sb_q        <= sb_d;
        end
    end
endmodule

// File: tb/tb_core_writeback.sv
// Bench for core_writeback: directed scenarios plus random EX/load traffic,
// all checked cycle by cycle against a queue-based reference of the writeback rules.
module tb_core_writeback;
    localparam int LQ_DEPTH   = 2;
    localparam int STARVE_MAX = 4;
    localparam config_pkg::cfg_t CONF_E = '{XLEN: 32, E_SUPPORTED: 1'b1};

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } beat_t;

    logic clk;
    logic rst;

    core_writeback_if #(.XLEN(32), .NUMREGS(32)) bus ();
    core_writeback_if #(.XLEN(32), .NUMREGS(16)) bus_e ();

    core_writeback #(
        .CONF       (config_pkg::DEFAULT_CONF),
        .LQ_DEPTH   (LQ_DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    core_writeback #(
        .CONF       (CONF_E),
        .LQ_DEPTH   (LQ_DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut_e (
        .clk (clk),
        .rst (rst),
        .wb  (bus_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: pending loads, consecutive EX wins over waiting loads, busy regs.
    beat_t       ldq[$];
    int          ex_wins = 0;
    logic [31:0] sb_m = '0;
    int          obs_streak = 0;
    logic        obs_ex_ready, obs_ld_ready;
    logic        last_ex_acc, last_ld_acc;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of traffic on the main DUT, with every observable checked against the reference.
    task automatic applyStimulus(input logic ev, input logic [4:0] erd, input logic [31:0] edata,
                                 input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
                                 input logic iv, input logic [4:0] ird);
        beat_t cb;
        logic  m_ex_ready, m_ld_ready, c_ex, c_ld, exp_we;
        bit    waiting;
        @(negedge clk);
        bus.ex_valid  = ev;  bus.ex_rd  = erd; bus.ex_data = edata;
        bus.ld_valid  = lv;  bus.ld_rd  = lrd; bus.ld_data = ldata;
        bus.iss_valid = iv;  bus.iss_rd = ird;
        #1;
        waiting      = (ldq.size() > 0);
        m_ld_ready   = (ldq.size() < LQ_DEPTH);
        m_ex_ready   = !(ex_wins == STARVE_MAX && waiting);
        obs_ex_ready = bus.ex_ready;
        obs_ld_ready = bus.ld_ready;
        checkOutput("ex_ready", obs_ex_ready, m_ex_ready);
        checkOutput("ld_ready", obs_ld_ready, m_ld_ready);

        if (ev && obs_ex_ready && waiting) obs_streak++;
        else obs_streak = 0;
        checkOutput("starve_bound", obs_streak > STARVE_MAX, 0);

        c_ex = ev && m_ex_ready;
        c_ld = !c_ex && waiting;
        cb.rd = 5'd0; cb.data = '0;
        if (c_ex) begin
            cb.rd = erd; cb.data = edata;
        end else if (c_ld) begin
            cb = ldq.pop_front();
        end
        if (c_ld || !waiting) ex_wins = 0;
        else if (c_ex && ex_wins < STARVE_MAX) ex_wins++;
        if (lv && m_ld_ready) begin
            beat_t nb;
            nb.rd = lrd; nb.data = ldata;
            ldq.push_back(nb);
        end
        if (c_ld) sb_m[cb.rd] = 1'b0;
        if (iv) sb_m[ird] = 1'b1;
        sb_m[0] = 1'b0;
        exp_we      = (c_ex || c_ld) && (cb.rd != 5'd0);
        last_ex_acc = c_ex;
        last_ld_acc = lv && m_ld_ready;

        @(posedge clk);
        #1;
        checkOutput("rf_we2", bus.rf_we2, exp_we);
        checkOutput("illegal_rd", bus.illegal_rd, 0);
        checkOutput("sb_busy", bus.sb_busy, sb_m);
        if (exp_we) begin
            checkOutput("rf_a2", bus.rf_a2, cb.rd);
            checkOutput("rf_wd2", bus.rf_wd2, cb.data);
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int          ex_idx, ld_idx, ex_pct;
        logic        ex_pend;
        logic [4:0]  ex_prd;
        logic [31:0] ex_pdata;

        rst = 1'b1;
        bus.ex_valid = 0; bus.ex_rd = 0; bus.ex_data = 0;
        bus.ld_valid = 0; bus.ld_rd = 0; bus.ld_data = 0;
        bus.iss_valid = 0; bus.iss_rd = 0;
        bus_e.ex_valid = 0; bus_e.ex_rd = 0; bus_e.ex_data = 0;
        bus_e.ld_valid = 0; bus_e.ld_rd = 0; bus_e.ld_data = 0;
        bus_e.iss_valid = 0; bus_e.iss_rd = 0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_we", bus.rf_we2, 0);
        checkOutput("reset_a2", bus.rf_a2, 0);
        checkOutput("reset_wd2", bus.rf_wd2, 0);
        checkOutput("reset_illegal", bus.illegal_rd, 0);
        checkOutput("reset_sb", bus.sb_busy, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single EX write and its one-cycle pulse
        applyStimulus(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        checkOutput("single_we", bus.rf_we2, 1);
        checkOutput("single_a2", bus.rf_a2, 5);
        checkOutput("single_wd2", bus.rf_wd2, 32'hDEADBEEF);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("single_we_drop", bus.rf_we2, 0);

        // x0 write is accepted but suppressed
        applyStimulus(1, 5'd0, 32'h1234, 0, 0, 0, 0, 0);
        checkOutput("x0_accepted", obs_ex_ready, 1);
        checkOutput("x0_we", bus.rf_we2, 0);

        // Scoreboard set/clear, then set winning over a same-cycle clear
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd7);
        checkOutput("sb_set", bus.sb_busy[7], 1);
        applyStimulus(0, 0, 0, 1, 5'd7, 32'h77, 0, 0);
        checkOutput("sb_pending", bus.sb_busy[7], 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("sb_clear", bus.sb_busy[7], 0);
        checkOutput("sb_clear_we", bus.rf_we2, 1);
        checkOutput("sb_clear_a2", bus.rf_a2, 7);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd7);
        applyStimulus(0, 0, 0, 1, 5'd7, 32'h78, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd7);
        checkOutput("sb_set_wins", bus.sb_busy[7], 1);
        checkOutput("sb_set_wins_we", bus.rf_we2, 1);
        idleCycles(2);

        // FIFO full under continuous EX, then forced load commit
        ex_idx = 0; ld_idx = 0;
        for (int cyc = 0; cyc < 18; cyc++) begin
            applyStimulus(ex_idx < 10, 5'(10 + ex_idx), 32'hE000 + ex_idx,
                          ld_idx < 3, 5'(20 + ld_idx), 32'hA000 + ld_idx, 0, 0);
            if (cyc == 2) checkOutput("full_ld_ready", obs_ld_ready, 0);
            if (cyc == 5) begin
                checkOutput("full_ex_stall", obs_ex_ready, 0);
                checkOutput("full_first_ld_a2", bus.rf_a2, 20);
                checkOutput("full_first_ld_wd2", bus.rf_wd2, 32'hA000);
            end
            if (last_ex_acc) ex_idx++;
            if (last_ld_acc) ld_idx++;
        end
        idleCycles(3);

        // Reset mid-stream with two loads queued and a busy register
        applyStimulus(1, 5'd3, 32'h33, 1, 5'd12, 32'hC12, 1, 5'd9);
        applyStimulus(1, 5'd4, 32'h44, 1, 5'd13, 32'hC13, 0, 0);
        @(negedge clk);
        bus.ex_valid = 0; bus.ld_valid = 0; bus.iss_valid = 0;
        rst = 1'b1;
        #1;
        checkOutput("midrst_we", bus.rf_we2, 0);
        checkOutput("midrst_sb", bus.sb_busy, 0);
        ldq.delete();
        ex_wins = 0;
        sb_m = '0;
        obs_streak = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midrst_ld_ready", bus.ld_ready, 1);
        checkOutput("midrst_ex_ready", bus.ex_ready, 1);
        idleCycles(4);

        // E mode: rd>=16 load is consumed, not written, and flags illegal once
        @(negedge clk);
        bus_e.ld_valid = 1; bus_e.ld_rd = 5'd20; bus_e.ld_data = 32'hBAD;
        bus_e.iss_valid = 1; bus_e.iss_rd = 5'd20;
        @(posedge clk); #1;
        checkOutput("e_iss_ignored", bus_e.sb_busy, 0);
        checkOutput("e_no_early_illegal", bus_e.illegal_rd, 0);
        @(negedge clk);
        bus_e.ld_valid = 0; bus_e.iss_valid = 0;
        @(posedge clk); #1;
        checkOutput("e_illegal_we", bus_e.rf_we2, 0);
        checkOutput("e_illegal_pulse", bus_e.illegal_rd, 1);
        @(posedge clk); #1;
        checkOutput("e_illegal_once", bus_e.illegal_rd, 0);
        checkOutput("e_fifo_drained", bus_e.ld_ready, 1);

        // Random traffic; EX beats are held until accepted
        ex_pend = 0; ex_prd = 0; ex_pdata = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            ex_pct = (cyc < 200) ? 90 : 50;
            if (!ex_pend && ($urandom_range(0, 99) < ex_pct)) begin
                ex_pend  = 1;
                ex_prd   = 5'($urandom_range(0, 31));
                ex_pdata = $urandom;
            end
            applyStimulus(ex_pend, ex_prd, ex_pdata,
                          $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
                          $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)));
            if (last_ex_acc) ex_pend = 0;
        end
        idleCycles(6);
        checkOutput("random_drained", ldq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
